// File: rtl/gpr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_pkg
//  Description : Shared types and helpers for the gpr_mp register file:
//                sequencer state encoding, byte-merge helper and the
//                depth-from-address-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpr_pkg;

    // Sequencer states: idle, scrubbing the array, dumping the array
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DUMP  = 2'd2
    } state_t;

    // Number of registers addressed by an address of the given width
    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

    // One byte lane of a byte-enabled write: take the new byte when enabled
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpr_seq.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_seq
//  Description : Scrub / dump sequencer for gpr_mp. Owns the state machine
//                and the shared index counter; the index addresses the
//                register being cleared (CLEAR) or presented (DUMP).
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_seq
    import gpr_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic              clr_busy,
    output logic              clr_strobe,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] idx
);

    // Terminal index is compared explicitly so that wrap never ends a sequence
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(depth_of(ADDR_W) - 1);

    state_t state;

    // The array clears register idx on every cycle spent in CLEAR
    assign clr_strobe = (state == ST_CLEAR);

    // State machine, index counter and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            clr_busy   <= 1'b0;
            dump_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (clr_req) begin
                        state    <= ST_CLEAR;
                        clr_busy <= 1'b1;
                    end else if (dump_req) begin
                        state      <= ST_DUMP;
                        dump_valid <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (idx == LAST_IDX) begin
                        state    <= ST_IDLE;
                        clr_busy <= 1'b0;
                        idx      <= '0;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                ST_DUMP: begin
                    if (dump_ready) begin
                        if (idx == LAST_IDX) begin
                            state      <= ST_IDLE;
                            dump_valid <= 1'b0;
                            idx        <= '0;
                        end else begin
                            idx <= idx + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    idx        <= '0;
                    clr_busy   <= 1'b0;
                    dump_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/gpr_mp.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_mp
//  Description : Parametrised multi-read-port register file with byte-enable
//                writes, optional write-to-read bypass, a sequenced scrub
//                engine and a ready/valid register-dump port.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpr_mp
    import gpr_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic [DATA_W/8-1:0]        wbe,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    input  logic                       clr_req,
    output logic                       clr_busy,
    input  logic                       dump_req,
    output logic                       dump_valid,
    input  logic                       dump_ready,
    output logic [ADDR_W-1:0]          dump_idx,
    output logic [DATA_W-1:0]          dump_data
);

    localparam int DEPTH  = depth_of(ADDR_W);
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] wr_old;
    logic [DATA_W-1:0] wr_merged;
    logic              wr_hit;
    logic              clr_strobe;
    logic [ADDR_W-1:0] seq_idx;

    gpr_seq #(
        .ADDR_W (ADDR_W)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (clr_req),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .clr_busy   (clr_busy),
        .clr_strobe (clr_strobe),
        .dump_valid (dump_valid),
        .idx        (seq_idx)
    );

    assign dump_idx = seq_idx;

    // The merged word is both what gets stored and what the bypass forwards,
    // so a forwarded read always equals the post-edge register contents.
    assign wr_old = regs[waddr];

    generate
        for (genvar k = 0; k < NBYTES; k++) begin : g_byte
            assign wr_merged[8*k +: 8] = byte_merge(wr_old[8*k +: 8],
                                                    wdata[8*k +: 8], wbe[k]);
        end
    endgenerate

    // Writes are locked out during a scrub and never land in a hardwired r0
    assign wr_hit = we && !clr_strobe && ((ZERO_REG == 0) || (waddr != '0));

    // Register array: async clear, scrub one entry per cycle, else write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs <= '{default: '0};
        end else if (clr_strobe) begin
            regs[seq_idx] <= '0;
        end else if (wr_hit) begin
            regs[waddr] <= wr_merged;
        end
    end

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            logic [DATA_W-1:0] stored;
            assign ra     = raddr[p*ADDR_W +: ADDR_W];
            assign stored = ((ZERO_REG != 0) && (ra == '0)) ? '0 : regs[ra];
            // wr_hit already excludes the scrub and the hardwired zero register
            assign rdata[p*DATA_W +: DATA_W] =
                ((BYPASS != 0) && wr_hit && (ra == waddr)) ? wr_merged : stored;
        end
    endgenerate

    // Dump beat shows the live stored value; zero when no dump is running
    assign dump_data = !dump_valid                          ? '0 :
                       ((ZERO_REG != 0) && (seq_idx == '0)) ? '0 :
                                                              regs[seq_idx];

endmodule
`default_nettype wire

// File: tb/tb_gpr_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_mp
//  Description : Self-checking bench for gpr_mp. A bypassing instance and a
//                non-bypassing instance share all inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpr_mp;

    logic        clk;
    logic        rst;
    logic        we;
    logic [3:0]  wbe;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        clr_req;
    logic        dump_req;
    logic        dump_ready;

    logic [63:0] rdata,      nb_rdata;
    logic        clr_busy,   nb_clr_busy;
    logic        dump_valid, nb_dump_valid;
    logic [4:0]  dump_idx,   nb_dump_idx;
    logic [31:0] dump_data,  nb_dump_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [32];

    gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .clr_busy(clr_busy),
        .dump_req(dump_req), .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_idx(dump_idx), .dump_data(dump_data)
    );

    gpr_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .we(we), .wbe(wbe), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(nb_rdata), .clr_req(clr_req), .clr_busy(nb_clr_busy),
        .dump_req(dump_req), .dump_valid(nb_dump_valid), .dump_ready(dump_ready),
        .dump_idx(nb_dump_idx), .dump_data(nb_dump_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Single full-cycle write, aligned so the edge commits it
    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d; wbe = be;
        @(posedge clk);
        #1 we = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  wbe;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [31:0] enb;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int n;
        int k;
        int exp_idx;
        logic done;

        //                we    wbe    wa     wdata          ra0   ra1   e0            e1            enb (no bypass, port0)
        vecs[0] = '{1'b1, 4'hF, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 4'h2, 5'd5, 32'h00005500, 5'd5, 5'd5, 32'hDEAD55EF, 32'hDEAD55EF, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'hF, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'hDEAD55EF, 32'h0};
        vecs[3] = '{1'b0, 4'hF, 5'd0, 32'h0,        5'd0, 5'd5, 32'h0,        32'hDEAD55EF, 32'h0};
        vecs[4] = '{1'b1, 4'hF, 5'd7, 32'hAAAAAAAA, 5'd7, 5'd7, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0};
        vecs[5] = '{1'b1, 4'hC, 5'd7, 32'h12345678, 5'd7, 5'd7, 32'h1234AAAA, 32'h1234AAAA, 32'hAAAAAAAA};
        vecs[6] = '{1'b0, 4'h0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h1234AAAA, 32'hDEAD55EF, 32'h1234AAAA};
        vecs[7] = '{1'b1, 4'h0, 5'd5, 32'hFFFFFFFF, 5'd5, 5'd5, 32'hDEAD55EF, 32'hDEAD55EF, 32'hDEAD55EF};
        vecs[8] = '{1'b0, 4'h0, 5'd0, 32'h0,        5'd5, 5'd7, 32'hDEAD55EF, 32'h1234AAAA, 32'hDEAD55EF};

        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        rst = 1'b0; we = 1'b0; wbe = 4'h0; waddr = 5'd0; wdata = 32'h0;
        raddr = 10'h0; clr_req = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;

        // Reset state
        #3;
        chk("rst_clr_busy",   {31'h0, clr_busy},   32'h0);
        chk("rst_dump_valid", {31'h0, dump_valid}, 32'h0);
        chk("rst_dump_idx",   {27'h0, dump_idx},   32'h0);
        chk("rst_dump_data",  dump_data,           32'h0);
        chk("rst_rdata0",     rdata[31:0],         32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Writes, byte enables, r0, bypass vs no bypass
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            we = vecs[i].we; wbe = vecs[i].wbe; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
            raddr = {vecs[i].ra1, vecs[i].ra0};
            #1;
            chk($sformatf("vec%0d_rd0", i),    rdata[31:0],    vecs[i].e0);
            chk($sformatf("vec%0d_rd1", i),    rdata[63:32],   vecs[i].e1);
            chk($sformatf("vec%0d_nb_rd0", i), nb_rdata[31:0], vecs[i].enb);
        end
        @(negedge clk);
        we = 1'b0;

        // Scrub: fill, clear, count busy cycles, locked-out write
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101, 4'hF);
        @(negedge clk); clr_req = 1'b1;
        @(negedge clk); clr_req = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            if (n == 0) begin
                we = 1'b1; waddr = 5'd3; wdata = 32'hFFFFFFFF; wbe = 4'hF; raddr = {5'd3, 5'd3};
                #1 chk("clr_read_no_bypass", rdata[31:0], 32'h03030303);
            end
            @(negedge clk);
            we = 1'b0;
            n++;
        end
        chk("clr_busy_cycles", 32'(n), 32'd32);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int i = 0; i < 32; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("clr_r%0d", i), rdata[31:0], 32'h0);
        end

        // Dump with ready toggling; write to a not-yet-dumped register
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101, 4'hF);
        @(negedge clk); dump_req = 1'b1;
        @(negedge clk); dump_req = 1'b0;
        exp_idx = 0; k = 0; done = 1'b0;
        while (!done && k < 200) begin
            dump_ready = (k % 2 == 0);
            we = (k == 4); waddr = 5'd20; wdata = 32'hCAFEF00D; wbe = 4'hF;
            #1;
            chk("dump_valid", {31'h0, dump_valid}, 32'h1);
            chk("dump_idx",   {27'h0, dump_idx},   32'(exp_idx));
            chk("dump_data",  dump_data,           model[exp_idx]);
            if (k == 4) model[20] = 32'hCAFEF00D;
            if (dump_ready) begin
                if (exp_idx == 31) done = 1'b1;
                else exp_idx++;
            end
            k++;
            @(negedge clk);
        end
        we = 1'b0; dump_ready = 1'b0;
        chk("dump_completed", {31'h0, done}, 32'h1);
        #1;
        chk("dump_end_valid", {31'h0, dump_valid}, 32'h0);
        chk("dump_end_idx",   {27'h0, dump_idx},   32'h0);

        // Simultaneous clr_req/dump_req: scrub only; dump_req during scrub ignored
        @(negedge clk); clr_req = 1'b1; dump_req = 1'b1;
        @(negedge clk); clr_req = 1'b0; dump_req = 1'b0;
        #1;
        chk("prio_busy",  {31'h0, clr_busy},   32'h1);
        chk("prio_valid", {31'h0, dump_valid}, 32'h0);
        @(negedge clk); dump_req = 1'b1;
        @(negedge clk); dump_req = 1'b0;
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            if (dump_valid !== 1'b0) chk("prio_valid_in_clear", {31'h0, dump_valid}, 32'h0);
            @(negedge clk);
            n++;
        end
        chk("prio_busy_done", {31'h0, clr_busy}, 32'h0);
        repeat (3) @(negedge clk);
        chk("prio_valid_after", {31'h0, dump_valid}, 32'h0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;

        // Reset mid-dump at idx 12, then restart
        wr(5'd12, 32'h0C0C0C0C, 4'hF);
        wr(5'd31, 32'h1F1F1F1F, 4'hF);
        @(negedge clk); dump_req = 1'b1; dump_ready = 1'b1;
        @(negedge clk); dump_req = 1'b0;
        n = 0;
        while (dump_idx !== 5'd12 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("mid_dump_reached_12", {27'h0, dump_idx}, 32'd12);
        chk("mid_dump_data12",     dump_data,         32'h0C0C0C0C);
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, dump_valid}, 32'h0);
        chk("mid_rst_idx",   {27'h0, dump_idx},   32'h0);
        chk("mid_rst_busy",  {31'h0, clr_busy},   32'h0);
        raddr = {5'd31, 5'd12};
        #1;
        chk("mid_rst_r12", rdata[31:0],  32'h0);
        chk("mid_rst_r31", rdata[63:32], 32'h0);
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        @(negedge clk); dump_req = 1'b1;
        @(negedge clk); dump_req = 1'b0;
        #1;
        chk("restart_valid", {31'h0, dump_valid}, 32'h1);
        chk("restart_idx",   {27'h0, dump_idx},   32'h0);
        chk("restart_data",  dump_data,           32'h0);
        n = 0;
        while (dump_valid === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("restart_beats", 32'(n), 32'd32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised general-purpose register file for the MIPS-lite core.
- Replaces the fixed 32x32, 2-read/1-write file; adds:
  - configurable width, depth and read-port count
  - byte-enable writes
  - write-to-read bypass
  - sequenced scrub (clear) engine
  - handshaked register-dump port, used by the bench in place of console prints
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; DEPTH = 2**ADDR_W registers.
- NUM_RD, 2: number of independent combinational read ports, 1..4.
- ZERO_REG, 1: 1 = register 0 is hardwired to zero; 0 = register 0 is writable.
- BYPASS, 1: 1 = same-cycle write data is forwarded to matching read ports.

Ports:
- clk, input, 1: clock; all state updates on rising edge.
- rst, input, 1: asynchronous, active-low reset.
- we, input, 1: write enable.
- wbe, input, DATA_W/8: byte enables for the write; bit k covers bits [8k+7:8k].
- waddr, input, ADDR_W: write address.
- wdata, input, DATA_W: write data.
- raddr, input, NUM_RD*ADDR_W: read addresses; port p uses slice [p*ADDR_W +: ADDR_W].
- rdata, output, NUM_RD*DATA_W: read data; port p uses slice [p*DATA_W +: DATA_W].
- clr_req, input, 1: one-cycle pulse requesting a scrub of all registers.
- clr_busy, output, 1: high while a scrub is in progress.
- dump_req, input, 1: one-cycle pulse requesting a dump of all registers.
- dump_valid, output, 1: dump_idx and dump_data are valid.
- dump_ready, input, 1: consumer accepts the current dump beat.
- dump_idx, output, ADDR_W: index of the register being dumped.
- dump_data, output, DATA_W: stored value of register dump_idx.

Behaviour:
- Reset (rst low, asynchronous):
  - all registers cleared to 0; FSM to IDLE; index counter 0.
  - clr_busy=0, dump_valid=0, dump_idx=0, dump_data=0.
  - rdata reflects the cleared array (all 0).
  - Reset mid-scrub or mid-dump aborts immediately; no partial-beat completion.
- Writes:
  - On a rising edge with we=1 and (waddr!=0 or ZERO_REG=0), each byte k with wbe[k]=1 takes wdata's byte k; other bytes hold.
  - wbe=0 is a legal no-op.
  - Writes are ignored while clr_busy=1.
- Reads:
  - Combinational, zero latency.
  - Address 0 with ZERO_REG=1 returns 0 regardless of any write.
  - With BYPASS=1, we=1, clr_busy=0, and raddr_p==waddr (and not the zero register): rdata_p = stored value with wbe-selected bytes replaced by wdata, i.e. exactly the value the register holds after the edge.
  - With BYPASS=0, reads return the pre-edge stored value.
- FSM states: IDLE, CLEAR, DUMP.
  - IDLE -> CLEAR on clr_req. This has priority when clr_req and dump_req arrive in the same cycle; that dump_req is dropped.
  - IDLE -> DUMP on dump_req (without clr_req).
  - clr_req and dump_req are ignored outside IDLE.
- CLEAR:
  - clr_busy=1 starting the cycle after clr_req.
  - Index counter runs 0..DEPTH-1, clearing one register per cycle; the scrub takes exactly DEPTH cycles.
  - The cycle after register DEPTH-1 is cleared: return to IDLE, clr_busy=0.
  - Reads during CLEAR return current array contents, so some registers are already cleared and others not; no bypass is applied.
- DUMP:
  - dump_valid=1 starting the cycle after dump_req; dump_idx begins at 0.
  - dump_data is the live stored value of register dump_idx (register 0 reads 0 when ZERO_REG=1).
  - A beat is transferred on a cycle with dump_valid && dump_ready; dump_idx then increments.
  - dump_idx, and the dump_data register it selects, hold while dump_ready=0. dump_data may change while dump_ready=0 if a write hits register dump_idx.
  - After the beat at index DEPTH-1 transfers: dump_valid=0, dump_idx returns to 0, FSM returns to IDLE.
  - Writes are permitted during DUMP: a write to a register not yet dumped is visible in its beat; a write to an already-dumped register is not re-sent.
- Wrap-around: the index counter is ADDR_W bits. Terminal detection uses idx==DEPTH-1, never counter overflow.

Decomposition:
- Shared package gpr_pkg:
  - state enum (IDLE, CLEAR, DUMP)
  - byte-merge function (old, new, be) -> merged
  - constant DEPTH derived from ADDR_W
- One natural sub-module: gpr_seq (FSM plus index counter, driving clr_busy, dump_valid, dump_idx and the clear strobe). The array, bypass and read muxes stay in gpr_mp.

Test Plan:
1. Reset, then write r5=0xDEADBEEF with wbe=4'hF; next cycle write wbe=4'b0010, wdata=0x00005500 -> read r5=0xDEAD55EF; write to r0 -> r0 reads 0.
2. Same-cycle bypass: we=1, waddr=7, wdata=0x12345678, wbe=4'b1100, r7 previously 0xAAAAAAAA, raddr0=raddr1=7 -> both rdata=0x1234AAAA that cycle (BYPASS=1). With BYPASS=0 -> 0xAAAAAAAA.
3. Fill r1..r31 with index*0x01010101, pulse clr_req -> clr_busy high for exactly 32 cycles, a concurrent write to r3 is ignored, all registers read 0 afterwards.
4. Dump with dump_ready toggling 1,0,1,... -> 32 beats, idx 0..31 in order with matching data; idx holds during ready=0; dump_valid drops after beat 31.
5. clr_req and dump_req in the same cycle -> scrub only, dump_valid stays 0. dump_req pulsed during CLEAR -> ignored.
6. Assert rst mid-dump at idx=12 -> dump_valid=0 and dump_idx=0 immediately; all registers 0; a fresh dump_req restarts at idx 0.
